wb_vram_slave: RTL
==================

WB_VRAM_SLAVE -- requirements
Module: wb_vram_slave

Interface
REQ-001 Parameter ADDR_BITS, default 10, word-address width of internal RAM (1024 x 32 bit).
REQ-002 Parameter BASE_ADDR, default 30'h0, value matched against wbs_addr_i[31:ADDR_BITS+2]; mismatch is out of range.
REQ-003 Parameter WAIT_CYCLES, default 0, extra wait cycles before the first ack of each transaction (0..7).
REQ-004 clk_bus  in  1  bus clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone B3 cycle, strobe and write enable.
REQ-007 wbs_addr_i  in  30  word address [31:2].
REQ-008 wbs_cti_i  in  3 / wbs_bte_i  in  2  cycle type and burst type.
REQ-009 wbs_sel_i  in  4  byte lanes; wbs_data_i  in  32  write data.
REQ-010 wbs_data_o  out  32  read data, valid while wbs_ack_o is high.
REQ-011 wbs_ack_o / wbs_err_o  out  1 each  normal and error termination.

Function
REQ-012 FSM states: IDLE, WAIT, ACK, BURST, ERR.
REQ-013 IDLE: on cyc&stb with address out of range -> ERR; otherwise -> WAIT if WAIT_CYCLES>0, else -> ACK. Address, we, sel, data and cti are latched.
REQ-014 WAIT: counts WAIT_CYCLES cycles, then -> ACK. A read issues the RAM read in the last WAIT cycle, or in IDLE when WAIT_CYCLES=0.
REQ-015 ACK: wbs_ack_o=1 for exactly one cycle; first ack occurs 1+WAIT_CYCLES cycles after stb is first sampled.
REQ-016 Write: RAM byte lanes with sel bit=1 are written in the ACK cycle; lanes with sel bit=0 are unchanged; writes never enter BURST.
REQ-017 ACK, read with latched cti=3'b010: -> BURST. RAM read of the next address is issued in the same cycle. Any other cti -> IDLE.
REQ-018 BURST: wbs_ack_o = cyc & stb (combinational gate on a registered data-valid flag). Each acked beat advances the address and issues the next RAM read; data is valid on the following cycle.
REQ-019 Address advance per bte: 00 linear (+1, wrapping at 2^ADDR_BITS); 01/10/11 wrap within an aligned 4/8/16-word block (upper bits held, low 2/3/4 bits increment modulo).
REQ-020 Master wait in BURST (stb=0, cyc=1): no ack; address and data held; resumes on next stb.
REQ-021 BURST: beat acked with cti=3'b111 -> IDLE after that beat. cti=000 or 001 on a beat -> acked, then IDLE.
REQ-022 ERR: wbs_err_o=1 for one cycle, no RAM access, -> IDLE; wbs_ack_o and wbs_err_o are never both high.
REQ-023 cyc=0 in any state -> IDLE next cycle, ack/err low; a pending write is discarded.
REQ-024 wbs_data_o = 0 whenever wbs_ack_o=0.

Reset
REQ-025 rst -> state IDLE, wbs_ack_o=0, wbs_err_o=0, wbs_data_o=0, wait counter 0, data-valid flag 0.
REQ-026 RAM contents are not cleared by rst; rst mid-burst aborts with no further ack.

Structure
REQ-027 CTI/BTE encodings and FSM state constants are placed in the shared define.vh.
REQ-028 One sub-module wb_vram_ram: single-port synchronous RAM, 32-bit, 4 byte write enables, 1-cycle read latency.
REQ-029 Burst address-wrap logic stays in wb_vram_slave.

Verification
REQ-030 Classic write 0x12345678 to addr 0x005, sel=1111, then classic read of 0x005 -> each acked 1 cycle after stb; read returns 0x12345678.
REQ-031 Write addr 0x005 sel=0010 data 0x0000AB00 over prior 0x12345678 -> read returns 0x1234AB78.
REQ-032 RAM[n]=n preloaded; incrementing read burst from 0x00E, bte=01, 4 beats, last cti=111 -> ack 4 consecutive cycles, data 0x00E,0x00F,0x00C,0x00D, then IDLE.
REQ-033 Linear burst from 0x3FE, 3 beats, stb low one cycle after beat 1 -> data 0x3FE,0x3FF,0x000; no ack during the gap.
REQ-034 Access with addr[31:12]≠0 (BASE_ADDR=0) -> err one cycle after stb, no ack, RAM unchanged.
REQ-035 WAIT_CYCLES=3: classic read -> ack 4 cycles after stb; rst asserted mid-burst -> ack low the next cycle and state IDLE.

Source files
------------

// File: rtl/wb_vram_pkg.sv
// Shared encodings for the Wishbone VRAM slave:
// FSM states plus the Wishbone B3 cycle/burst type codes.
package wb_vram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_BURST,
    ST_ERR
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

endpackage

// File: rtl/wb_vram_ram.sv
// Single-port synchronous video RAM, 32-bit words,
// per-byte write enables, one-cycle registered read.
module wb_vram_ram #(
  parameter int AW = 10
) (
  input  logic          clk_bus,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk_bus) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/wb_vram_slave.sv
// Wishbone B3 slave in front of the video RAM with optional
// wait states and incrementing (linear / wrapping) read bursts.
module wb_vram_slave
  import wb_vram_pkg::*;
#(
  parameter int          ADDR_BITS   = 10,
  parameter logic [29:0] BASE_ADDR   = 30'h0,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk_bus,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [29:0] wbs_addr_i,
  input  logic [2:0]  wbs_cti_i,
  input  logic [1:0]  wbs_bte_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_data_i,
  output logic [31:0] wbs_data_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o
);

  localparam logic [2:0] WAIT_LAST =
    3'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

  state_t state, state_nx;

  logic [ADDR_BITS-1:0] addr_q, ram_addr, addr_adv;
  logic                 we_q;
  logic [3:0]           sel_q;
  logic [31:0]          data_q;
  logic [2:0]           cti_q;
  logic [1:0]           bte_q;
  logic [2:0]           wait_cnt;
  logic                 dvalid;
  logic [3:0]           ram_we;
  logic [31:0]          ram_rdata;
  logic                 in_range, burst_go;
  logic                 beat, burst_end;

  function automatic logic [ADDR_BITS-1:0] burst_next(
    input logic [ADDR_BITS-1:0] a,
    input logic [1:0]           bte
  );
    logic [ADDR_BITS-1:0] inc, mask;
    inc  = a + ADDR_BITS'(1);
    mask = '1;
    unique case (bte)
      BTE_LINEAR: mask = '1;
      BTE_WRAP4:  mask = ADDR_BITS'(3);
      BTE_WRAP8:  mask = ADDR_BITS'(7);
      BTE_WRAP16: mask = ADDR_BITS'(15);
    endcase
    return (a & ~mask) | (inc & mask);
  endfunction

  assign in_range = wbs_addr_i[29:ADDR_BITS]
                 == BASE_ADDR[29-ADDR_BITS:0];
  assign addr_adv = burst_next(addr_q, bte_q);
  assign burst_go = !we_q && cti_q == CTI_INCR;
  assign beat     = wbs_cyc_i & wbs_stb_i & dvalid;
  assign burst_end = wbs_cti_i == CTI_EOB
                  || wbs_cti_i == CTI_CLASSIC
                  || wbs_cti_i == CTI_CONST;

  always_ff @(posedge clk_bus) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!wbs_cyc_i) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:
          if (wbs_stb_i) begin
            if (!in_range)            state_nx = ST_ERR;
            else if (WAIT_CYCLES > 0) state_nx = ST_WAIT;
            else                      state_nx = ST_ACK;
          end
        ST_WAIT:
          if (wait_cnt == WAIT_LAST) state_nx = ST_ACK;
        ST_ACK:
          state_nx = burst_go ? ST_BURST : ST_IDLE;
        ST_BURST:
          if (beat && burst_end) state_nx = ST_IDLE;
        ST_ERR:
          state_nx = ST_IDLE;
        default:
          state_nx = ST_IDLE;
      endcase
    end
  end

  // RAM is read every cycle; the address chosen here is
  // what the next data-out cycle will present.
  always_comb begin
    ram_addr  = addr_q;
    ram_we    = '0;
    wbs_ack_o = 1'b0;
    wbs_err_o = 1'b0;
    unique case (state)
      ST_IDLE:
        ram_addr = wbs_addr_i[ADDR_BITS-1:0];
      ST_ACK: begin
        wbs_ack_o = wbs_cyc_i;
        if (we_q)          ram_we   = sel_q & {4{wbs_cyc_i}};
        else if (burst_go) ram_addr = addr_adv;
      end
      ST_BURST: begin
        wbs_ack_o = beat;
        if (beat) ram_addr = addr_adv;
      end
      ST_ERR:
        wbs_err_o = wbs_cyc_i;
      default: ;
    endcase
    wbs_data_o = wbs_ack_o ? ram_rdata : 32'h0;
  end

  always_ff @(posedge clk_bus) begin
    if (rst) begin
      wait_cnt <= '0;
      dvalid   <= 1'b0;
    end else begin
      wait_cnt <= (state == ST_WAIT && state_nx == ST_WAIT)
                ? wait_cnt + 3'd1 : 3'd0;
      dvalid   <= state_nx == ST_BURST;
    end
  end

  always_ff @(posedge clk_bus) begin
    addr_q <= ram_addr;
    if (state == ST_IDLE && wbs_cyc_i && wbs_stb_i) begin
      we_q   <= wbs_we_i;
      sel_q  <= wbs_sel_i;
      data_q <= wbs_data_i;
      cti_q  <= wbs_cti_i;
      bte_q  <= wbs_bte_i;
    end
  end

  wb_vram_ram #(.AW(ADDR_BITS)) u_ram (
    .clk_bus (clk_bus),
    .addr    (ram_addr),
    .we      (ram_we),
    .wdata   (data_q),
    .rdata   (ram_rdata)
  );

endmodule
